// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: opcodes, states,
// ALU operation codes and datapath mux select codes.
package mc_pkg;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WB   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_EXEC_R   = 4'd7,
      ST_EXEC_I   = 4'd8,
      ST_ALU_WB   = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JUMP     = 4'd11,
      ST_HALT     = 4'd15
   } state_t;

   localparam logic [1:0] ALU_NONE     = 2'd0;
   localparam logic [1:0] ALU_CMP      = 2'd1;
   localparam logic [1:0] ALU_ZERO_OUT = 2'd2;
   localparam logic [1:0] ALU_PLUS     = 2'd3;

   localparam logic [1:0] SRC_A_PC     = 2'd0;
   localparam logic [1:0] SRC_A_REG    = 2'd1;
   localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory bundle. The controller uses the master modport,
// the datapath side (or a testbench) uses the slave modport.
interface mc_control_if;
   logic [31:0] ir;
   logic        cond_true;
   logic        mem_ack;

   logic        mem_req;
   logic        mem_read;
   logic        mem_write;
   logic        i_or_d;
   logic        ir_write;
   logic        pc_write;
   logic        pc_write_cond;
   logic        pc_source;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        cmp_func;
   logic        reg_write;
   logic        memto_reg;
   logic        instr_done;
   logic        halted;
   logic [3:0]  state;

   modport master (
      input  ir, cond_true, mem_ack,
      output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
             pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op, cmp_func,
             reg_write, memto_reg, instr_done, halted, state
   );

   modport slave (
      output ir, cond_true, mem_ack,
      input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
             pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op, cmp_func,
             reg_write, memto_reg, instr_done, halted, state
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: picks the state that follows DECODE.
// Unsupported opcodes and branch funct3 values other than 000/111 halt the core.
module mc_decode
   import mc_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output state_t     nxt_state
);

   always_comb begin
      nxt_state = ST_HALT;
      case (opcode)
         OP_LW, OP_SW: nxt_state = ST_MEM_ADDR;
         OP_ADD:       nxt_state = ST_EXEC_R;
         OP_ADDI:      nxt_state = ST_EXEC_I;
         OP_BEQ:       if (funct3 == 3'b000 || funct3 == 3'b111) nxt_state = ST_BRANCH;
         OP_JAL:       nxt_state = ST_JUMP;
         default:      nxt_state = ST_HALT;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencing controller for the RV32 lab-subset CPU.
// Optional MC_STEP_EN: adds a step input and parks in IDLE after every instruction.
module mc_control
   import mc_pkg::*;
(
   input logic clk,
   input logic rst,
`ifdef MC_STEP_EN
   input logic step,
`endif
   mc_control_if.master bus
);

`ifdef MC_STEP_EN
   localparam state_t ST_AFTER = ST_IDLE;
`else
   localparam state_t ST_AFTER = ST_FETCH;
`endif

   state_t st, st_nxt, dec_nxt;

   // cond_true is consumed by the PC write gate in the datapath, not here
   logic unused_bits;
   assign unused_bits = &{1'b0, bus.cond_true, bus.ir[31:15], bus.ir[11:7]};

   mc_decode u_decode (
      .opcode    (bus.ir[6:0]),
      .funct3    (bus.ir[14:12]),
      .nxt_state (dec_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_IDLE;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
`ifdef MC_STEP_EN
         ST_IDLE:     if (step) st_nxt = ST_FETCH;
`else
         ST_IDLE:     st_nxt = ST_FETCH;
`endif
         ST_FETCH:    if (bus.mem_ack) st_nxt = ST_DECODE;
         ST_DECODE:   st_nxt = dec_nxt;
         ST_MEM_ADDR: st_nxt = (bus.ir[6:0] == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:   if (bus.mem_ack) st_nxt = ST_MEM_WB;
         ST_MEM_WR:   if (bus.mem_ack) st_nxt = ST_AFTER;
         ST_EXEC_R,
         ST_EXEC_I:   st_nxt = ST_ALU_WB;
         ST_MEM_WB,
         ST_ALU_WB,
         ST_BRANCH,
         ST_JUMP:     st_nxt = ST_AFTER;
         ST_HALT:     st_nxt = ST_HALT;
         default:     st_nxt = ST_HALT;
      endcase
   end

   always_comb begin
      bus.mem_req       = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = PC_SRC_ALU;
      bus.alu_src_a     = SRC_A_PC;
      bus.alu_src_b     = SRC_B_REG;
      bus.alu_op        = ALU_NONE;
      bus.cmp_func      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.memto_reg     = 1'b0;
      bus.instr_done    = 1'b0;
      bus.halted        = 1'b0;
      case (st)
         ST_FETCH: begin
            bus.mem_req   = 1'b1;
            bus.mem_read  = 1'b1;
            bus.alu_src_a = SRC_A_PC;
            bus.alu_src_b = SRC_B_FOUR;
            bus.alu_op    = ALU_PLUS;
            bus.ir_write  = bus.mem_ack;
            bus.pc_write  = bus.mem_ack;
         end
         // ALUOut captures old_pc + imm here as the branch/jump target
         ST_DECODE: begin
            bus.alu_src_a = SRC_A_OLD_PC;
            bus.alu_src_b = SRC_B_IMM;
            bus.alu_op    = ALU_PLUS;
         end
         ST_MEM_ADDR, ST_EXEC_I: begin
            bus.alu_src_a = SRC_A_REG;
            bus.alu_src_b = SRC_B_IMM;
            bus.alu_op    = ALU_PLUS;
         end
         ST_MEM_RD: begin
            bus.mem_req  = 1'b1;
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.memto_reg  = 1'b1;
            bus.instr_done = 1'b1;
         end
         ST_MEM_WR: begin
            bus.mem_req    = 1'b1;
            bus.mem_write  = 1'b1;
            bus.i_or_d     = 1'b1;
            bus.instr_done = bus.mem_ack;
         end
         ST_EXEC_R: begin
            bus.alu_src_a = SRC_A_REG;
            bus.alu_src_b = SRC_B_REG;
            bus.alu_op    = ALU_PLUS;
         end
         ST_ALU_WB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            bus.alu_src_a     = SRC_A_REG;
            bus.alu_src_b     = SRC_B_REG;
            bus.alu_op        = ALU_CMP;
            bus.cmp_func      = bus.ir[12];
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PC_SRC_ALUOUT;
            bus.instr_done    = 1'b1;
         end
         ST_JUMP: begin
            bus.pc_write   = 1'b1;
            bus.pc_source  = PC_SRC_ALUOUT;
            bus.alu_op     = ALU_ZERO_OUT;
            bus.instr_done = 1'b1;
         end
         ST_HALT: bus.halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.state = st;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected state/control sequences
// are built at instruction level from the published latency and handshake rules.
module tb_mc_control;

   localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
      S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6,
      S_EXEC_R = 4'd7, S_EXEC_I = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10,
      S_JUMP = 4'd11, S_HALT = 4'd15;

   typedef enum int {C_ADD, C_ADDI, C_LW, C_SW, C_BR, C_JAL, C_BAD} cls_t;

   typedef struct {
      logic [3:0] st;
      bit         ack;
      bit         stp;
      bit         last;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef MC_STEP_EN
   logic step = 1'b0;
`endif

   mc_control_if bus ();

   int   total = 0;
   int   bad = 0;
   bit   fresh = 1'b0;
   ent_t q[$];

   logic [31:0] instr_tab [7];
   cls_t        cls_tab [7];

   mc_control dut (
      .clk  (clk),
      .rst  (rst),
`ifdef MC_STEP_EN
      .step (step),
`endif
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Expected cycle list for one instruction, from fetch to its last cycle
   task automatic build(input cls_t c, input int wf, input int wm, input int idle0);
      q.delete();
`ifdef MC_STEP_EN
      for (int i = 0; i < idle0; i++) q.push_back('{S_IDLE, 1'b0, 1'b0, 1'b0});
      q.push_back('{S_IDLE, 1'b0, 1'b1, 1'b0});
`else
      if (idle0 < 0) $display("note: negative idle count");
      if (fresh) q.push_back('{S_IDLE, 1'b0, 1'b0, 1'b0});
`endif
      for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0, 1'b0, 1'b0});
      q.push_back('{S_FETCH, 1'b1, 1'b0, 1'b0});
      q.push_back('{S_DECODE, 1'b0, 1'b0, 1'b0});
      case (c)
         C_LW: begin
            q.push_back('{S_MEM_ADDR, 1'b0, 1'b0, 1'b0});
            for (int i = 0; i < wm; i++) q.push_back('{S_MEM_RD, 1'b0, 1'b0, 1'b0});
            q.push_back('{S_MEM_RD, 1'b1, 1'b0, 1'b0});
            q.push_back('{S_MEM_WB, 1'b0, 1'b0, 1'b1});
         end
         C_SW: begin
            q.push_back('{S_MEM_ADDR, 1'b0, 1'b0, 1'b0});
            for (int i = 0; i < wm; i++) q.push_back('{S_MEM_WR, 1'b0, 1'b0, 1'b0});
            q.push_back('{S_MEM_WR, 1'b1, 1'b0, 1'b1});
         end
         C_ADD: begin
            q.push_back('{S_EXEC_R, 1'b0, 1'b0, 1'b0});
            q.push_back('{S_ALU_WB, 1'b0, 1'b0, 1'b1});
         end
         C_ADDI: begin
            q.push_back('{S_EXEC_I, 1'b0, 1'b0, 1'b0});
            q.push_back('{S_ALU_WB, 1'b0, 1'b0, 1'b1});
         end
         C_BR:  q.push_back('{S_BRANCH, 1'b0, 1'b0, 1'b1});
         C_JAL: q.push_back('{S_JUMP, 1'b0, 1'b0, 1'b1});
         default: for (int i = 0; i < 10; i++) q.push_back('{S_HALT, 1'b0, 1'b0, 1'b0});
      endcase
   endtask

   // Walk the expected list one cycle at a time, checking at negedge + 1
   task automatic run_seq(input logic [31:0] instr, input string tag);
      logic [2:0]  f3;
      logic [10:0] fl_obs, fl_exp;
      logic [7:0]  mx_obs, mx_exp, mx_msk;
      ent_t        e;
      bit          in_mem;
      f3 = instr[14:12];
      fresh = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         in_mem = (e.st == S_FETCH) || (e.st == S_MEM_RD) || (e.st == S_MEM_WR);
         bus.ir        = instr;
         bus.cond_true = 1'($urandom_range(0, 1));
         bus.mem_ack   = in_mem ? e.ack : 1'($urandom_range(0, 1));
`ifdef MC_STEP_EN
         step = (e.st == S_IDLE) ? e.stp : 1'($urandom_range(0, 1));
`endif
         #1;
         total++;
         if (bus.state !== e.st) begin
            bad++;
            $display("FAIL %s state cyc=%0d got=%0d want=%0d", tag, i, bus.state, e.st);
         end
         fl_exp = {in_mem,
                   (e.st == S_FETCH) || (e.st == S_MEM_RD),
                   e.st == S_MEM_WR,
                   (e.st == S_MEM_RD) || (e.st == S_MEM_WR),
                   (e.st == S_FETCH) && e.ack,
                   ((e.st == S_FETCH) && e.ack) || (e.st == S_JUMP),
                   e.st == S_BRANCH,
                   (e.st == S_MEM_WB) || (e.st == S_ALU_WB),
                   e.st == S_MEM_WB,
                   e.last,
                   e.st == S_HALT};
         fl_obs = {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                   bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.memto_reg,
                   bus.instr_done, bus.halted};
         total++;
         if (fl_obs !== fl_exp) begin
            bad++;
            $display("FAIL %s flags cyc=%0d st=%0d got=%b want=%b", tag, i, e.st, fl_obs, fl_exp);
         end
         // mux word {src_a, src_b, alu_op, pc_source, cmp_func}
         mx_msk = 8'h00;
         mx_exp = 8'h00;
         case (e.st)
            S_IDLE, S_HALT: mx_msk = 8'hFF;
            S_FETCH:    begin mx_exp = {2'd0, 2'd1, 2'd3, 1'b0, 1'b0}; mx_msk = 8'hFE; end
            S_DECODE:   begin mx_exp = {2'd2, 2'd2, 2'd3, 2'b00}; mx_msk = 8'hFC; end
            S_MEM_ADDR,
            S_EXEC_I:   begin mx_exp = {2'd1, 2'd2, 2'd3, 2'b00}; mx_msk = 8'hFC; end
            S_EXEC_R:   begin mx_exp = {2'd1, 2'd0, 2'd3, 2'b00}; mx_msk = 8'hFC; end
            S_BRANCH:   begin mx_exp = {2'd1, 2'd0, 2'd1, 1'b1, f3[0]}; mx_msk = 8'hFF; end
            S_JUMP:     begin mx_exp = {4'd0, 2'd2, 1'b1, 1'b0}; mx_msk = 8'h0E; end
            default: ;
         endcase
         if (mx_msk != 8'h00) begin
            mx_obs = {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.cmp_func};
            total++;
            if ((mx_obs & mx_msk) !== (mx_exp & mx_msk)) begin
               bad++;
               $display("FAIL %s mux cyc=%0d st=%0d got=%b want=%b", tag, i, e.st,
                        mx_obs & mx_msk, mx_exp & mx_msk);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      logic [29:0] outs;
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      bus.ir = $urandom;
`ifdef MC_STEP_EN
      step = 1'b1;
`endif
      @(negedge clk);
      #1;
      outs = {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
              bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.cmp_func, bus.reg_write, bus.memto_reg, bus.instr_done,
              bus.halted, bus.state, 8'h00};
      total++;
      if (outs !== 30'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      @(negedge clk);
      rst = 1'b0;
`ifdef MC_STEP_EN
      step = 1'b0;
`endif
      fresh = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_add();
      build(C_ADD, 0, 0, 0);
      run_seq(32'h002081B3, "add");
   endtask

   task automatic test_lw_wait();
      build(C_LW, 0, 2, 1);
      run_seq(32'h0040A183, "lw_wait");
   endtask

   task automatic test_sw();
      build(C_SW, 1, 1, 0);
      run_seq(32'h0020A423, "sw");
   endtask

   task automatic test_branch();
      build(C_BR, 0, 0, 0);
      run_seq(32'h00208463, "beq1");
      build(C_BR, 0, 0, 0);
      run_seq(32'h00208463, "beq2");
      build(C_BR, 0, 0, 0);
      run_seq(32'h0020F463, "bgeu");
   endtask

   task automatic test_reset_mid();
      do_reset();
`ifdef MC_STEP_EN
      step = 1'b1;
`endif
      bus.mem_ack = 1'b0;
      @(negedge clk);
`ifdef MC_STEP_EN
      step = 1'b0;
`endif
      #1;
      total++;
      if (bus.state !== S_FETCH || bus.mem_req !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre state=%0d req=%b want state=1 req=1", bus.state, bus.mem_req);
      end
      #2;
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      total++;
      if ({bus.state, bus.mem_req, bus.ir_write, bus.pc_write} !== 7'd0) begin
         bad++;
         $display("FAIL mid_rst state=%0d req=%b irw=%b pcw=%b want all 0",
                  bus.state, bus.mem_req, bus.ir_write, bus.pc_write);
      end
      do_reset();
   endtask

   task automatic test_random();
      int idx;
      for (int n = 0; n < 40; n++) begin
         idx = int'($urandom_range(0, 6));
         build(cls_tab[idx], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)));
         run_seq(instr_tab[idx], $sformatf("rnd%0d", n));
      end
   endtask

   task automatic test_halt();
      do_reset();
      build(C_BAD, 0, 0, 0);
      run_seq(32'h00000000, "halt_zero");
      do_reset();
      build(C_BAD, 2, 0, 0);
      run_seq(32'h00209463, "halt_bne");
      do_reset();
      build(C_JAL, 0, 0, 0);
      run_seq(32'h008000EF, "after_halt");
   endtask

`ifdef MC_STEP_EN
   task automatic test_step();
      build(C_ADDI, 0, 0, 2);
      run_seq(32'h00108093, "step");
      step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (bus.state !== S_IDLE || bus.instr_done !== 1'b0) begin
            bad++;
            $display("FAIL step_park cyc=%0d state=%0d want=0", i, bus.state);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      instr_tab[0] = 32'h002081B3; cls_tab[0] = C_ADD;
      instr_tab[1] = 32'h00108093; cls_tab[1] = C_ADDI;
      instr_tab[2] = 32'h0040A183; cls_tab[2] = C_LW;
      instr_tab[3] = 32'h0020A423; cls_tab[3] = C_SW;
      instr_tab[4] = 32'h00208463; cls_tab[4] = C_BR;
      instr_tab[5] = 32'h0020F463; cls_tab[5] = C_BR;
      instr_tab[6] = 32'h008000EF; cls_tab[6] = C_JAL;
      bus.ir = 32'h0;
      bus.cond_true = 1'b0;
      bus.mem_ack = 1'b0;

      test_reset();
      test_add();
      test_lw_wait();
      test_sw();
      test_branch();
      test_reset_mid();
      test_random();
`ifdef MC_STEP_EN
      test_step();
`endif
      test_halt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench timeout");
   end

endmodule
